serial_adder: RTL
=================

Name: serial_adder

Overview:
Bit-serial WIDTH-bit adder built around the team's half_adder cell. Two half_adder instances plus an OR form a 1-bit full adder, and a carry flip-flop holds the carry between bits. Operands are accepted with a valid/ready handshake, added LSB-first over WIDTH clock cycles, and the result is presented with a valid/ready handshake. The block consumes half_adder sum/carry outputs and sits between an operand source and a result sink.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand pair on a/b is valid.
in_ready  output  1  block can accept operands (state IDLE).
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
out_valid  output  1  sum/carry_out hold a completed result.
out_ready  input  1  sink accepts the result.
sum  output  WIDTH  a+b modulo 2^WIDTH.
carry_out  output  1  carry out of the MSB.
busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, asynchronous):
  - state=IDLE, operand shift registers=0, sum register=0, carry FF=0, bit counter=0.
  - Outputs: in_ready=1, out_valid=0, sum=0, carry_out=0, busy=0.
- Output decode: in_ready=(state==IDLE); out_valid=(state==DONE); busy=(state!=IDLE). All decoded from registered state only, with no combinational path from inputs.
- FSM states:
  - IDLE: on in_valid&&in_ready at an edge, load a and b into shift registers, clear carry FF and counter, clear sum register, go to RUN.
  - RUN: each edge:
    - s = a_sr[0]^b_sr[0]^c; c_next = majority(a_sr[0], b_sr[0], c), taken from half_adder outputs (ha1 carry OR ha2 carry).
    - Shift s into sum register MSB, shift sum register right.
    - Shift a_sr and b_sr right; increment counter.
    - When counter==WIDTH-1 at the edge, go to DONE. carry_out latches c_next on that edge.
  - DONE: sum and carry_out held stable. On out_ready=1 at an edge, go to IDLE. Result registers keep their last value until the next load.
- Latency:
  - Acceptance at edge T0 gives RUN edges T1..TWIDTH.
  - out_valid is high from just after edge TWIDTH.
  - Minimum initiation interval is WIDTH+2 cycles (accept, WIDTH RUN cycles, 1 DONE cycle with out_ready=1).
- Handshake rules:
  - in_valid outside IDLE is ignored; a/b may change freely during RUN/DONE without affecting the result.
  - out_ready outside DONE is ignored.
  - Once out_valid rises it stays high, with sum/carry_out stable, until out_ready is sampled high.
- Arithmetic: {carry_out, sum} == a + b as an unsigned (WIDTH+1)-bit result.
- Boundary conditions:
  - WIDTH=1: single RUN cycle; result equals the half_adder truth table for cin=0.
  - Counter width is clog2(WIDTH)+1; no wrap is possible before the DONE transition.
  - Simultaneous out_ready in DONE and new in_valid: in_valid is not accepted on that edge, because in_ready=0. It is accepted on the next edge if still asserted.
  - Reset asserted mid-RUN or mid-DONE: immediate abort to reset values, and the partial result is discarded. After release, the first transaction behaves identically to one started from power-up.
  - a/b X or Z while in IDLE with in_valid=0: no effect.

Test Plan:
- Reset values: assert rst_n=0 for 3 cycles and release → in_ready=1, out_valid=0, busy=0, sum=8'h00, carry_out=0.
- Carry ripple: WIDTH=8, a=8'hFF, b=8'h01, accepted at edge T0 → out_valid rises after exactly 8 edges, sum=8'h00, carry_out=1.
- Random-style pairs:
  - a=8'hA5, b=8'h5A → sum=8'hFF, carry_out=0.
  - a=8'h80, b=8'h80 → sum=8'h00, carry_out=1.
  - a=8'h00, b=8'h00 → sum=8'h00, carry_out=0.
- Backpressure and ignored inputs: hold out_ready=0 for 5 cycles after out_valid → sum/carry_out and out_valid stable. Change a/b and pulse in_valid during RUN → result unchanged and no second transaction starts. Raise out_ready → IDLE next edge, in_ready=1.
- Reset mid-operation: start a=8'hFF, b=8'hFF, pull rst_n low after 3 RUN edges → outputs immediately at reset values. Next transaction a=8'h01, b=8'h02 → sum=8'h03, carry_out=0.
- WIDTH=1 exhaustive, back-to-back with out_ready tied high: (0,0)→0/0, (0,1)→1/0, (1,0)→1/0, (1,1)→0/1. Each transaction takes 3 cycles, accept to IDLE.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: a half_adder-based full adder plus a carry flip-flop,
// with valid/ready handshakes on the operand and result sides.

module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           next_state_s;
   logic [WIDTH-1:0] a_sr_r;
   logic [WIDTH-1:0] b_sr_r;
   logic [WIDTH-1:0] sum_r;
   logic [WIDTH-1:0] sum_shift_s;
   logic [CW-1:0]    cnt_r;
   logic             c_r;
   logic             carry_out_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             busy_r;
   logic             ha1_s_s;
   logic             ha1_c_s;
   logic             bit_s;
   logic             ha2_c_s;
   logic             c_next_s;
   logic             last_bit_s;

   // Full adder from two half adders: operand bits first, then the stored carry.
   half_adder u_ha1 (.a(a_sr_r[0]), .b(b_sr_r[0]), .s(ha1_s_s), .c(ha1_c_s));
   half_adder u_ha2 (.a(ha1_s_s),   .b(c_r),       .s(bit_s),   .c(ha2_c_s));

   assign c_next_s   = ha1_c_s | ha2_c_s;
   assign last_bit_s = (cnt_r == CW'(WIDTH - 1));

   // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
   always_comb begin
      sum_shift_s            = sum_r >> 1'b1;
      sum_shift_s[WIDTH-1]   = bit_s;
   end

   // Next-state decode.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) next_state_s = RUN;
            else          next_state_s = IDLE;
         end
         RUN: begin
            if (last_bit_s) next_state_s = DONE;
            else            next_state_s = RUN;
         end
         DONE: begin
            if (out_ready) next_state_s = IDLE;
            else           next_state_s = DONE;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // State register and handshake flags, the flags precomputed from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         in_ready_r  <= (next_state_s == IDLE);
         out_valid_r <= (next_state_s == DONE);
         busy_r      <= (next_state_s != IDLE);
      end
   end

   // Operand shift registers, sum accumulation, carry and bit counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr_r      <= '0;
         b_sr_r      <= '0;
         sum_r       <= '0;
         cnt_r       <= '0;
         c_r         <= 1'b0;
         carry_out_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  a_sr_r      <= a;
                  b_sr_r      <= b;
                  sum_r       <= '0;
                  cnt_r       <= '0;
                  c_r         <= 1'b0;
                  carry_out_r <= 1'b0;
               end
            end
            RUN: begin
               a_sr_r <= a_sr_r >> 1'b1;
               b_sr_r <= b_sr_r >> 1'b1;
               sum_r  <= sum_shift_s;
               cnt_r  <= cnt_r + CW'(1);
               c_r    <= c_next_s;
               if (last_bit_s) carry_out_r <= c_next_s;
            end
            default: begin
               sum_r <= sum_r;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign sum       = sum_r;
   assign carry_out = carry_out_r;

endmodule
